// File: rtl/chk_sched.sv
// rtl/chk_sched.sv - round-robin sig/rfr compare scheduler with sticky error status
// Optional per-slot sticky error bitmap is built when CHK_SCHED_ERRMAP_EN is defined.
module chk_sched #(
  parameter int NSLOTS = 8,
  parameter int WIDTH  = 32,
  parameter int SELW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NSLOTS-1:0] req,
  input  logic [WIDTH-1:0]  sig_in,
  input  logic [WIDTH-1:0]  rfr_in,
  output logic [SELW-1:0]   sel,
  output logic [NSLOTS-1:0] grant,
  output logic              check,
  output logic [NSLOTS-1:0] ack,
  output logic              mismatch,
  output logic              err,
  output logic [15:0]       err_count,
  output logic [SELW-1:0]   err_slot,
  output logic              busy,
  output logic [NSLOTS-1:0] err_map
);

  typedef enum logic [1:0] {IDLE, SEL, CHK, ACK} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q;
  logic [NSLOTS-1:0] ack_mask_q;
  logic [NSLOTS-1:0] elig;
  logic [SELW:0]     sum;
  logic [SELW-1:0]   idx;
  logic [SELW-1:0]   win_idx;
  logic              win_found;
  logic              err_hit;

  // The slot acked in the previous cycle is masked so a requester that is
  // still dropping req cannot be granted twice.
  always_comb begin
    elig      = req & ~ack_mask_q;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      sum = {1'b0, ptr_q} + (SELW+1)'(i);
      if (sum >= (SELW+1)'(NSLOTS)) sum = sum - (SELW+1)'(NSLOTS);
      idx = sum[SELW-1:0];
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && win_found) state_d = SEL;
      SEL:     state_d = CHK;
      CHK:     state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel        <= '0;
      grant      <= '0;
      check      <= 1'b0;
      ack        <= '0;
      mismatch   <= 1'b0;
      busy       <= 1'b0;
      ack_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      check      <= (state_d == CHK);
      ack        <= '0;
      mismatch   <= 1'b0;
      ack_mask_q <= '0;
      case (state_q)
        IDLE: begin
          if (state_d == SEL) begin
            sel   <= win_idx;
            grant <= {{(NSLOTS-1){1'b0}}, 1'b1} << win_idx;
          end
        end
        CHK: begin
          ack      <= grant;
          mismatch <= (sig_in != rfr_in);
        end
        ACK: begin
          ptr_q      <= (sel == SELW'(NSLOTS-1)) ? '0 : sel + 1'b1;
          ack_mask_q <= grant;
          grant      <= '0;
          sel        <= '0;
        end
        default: ;
      endcase
    end
  end

  // Error status is committed on the edge leaving ACK; a clear sampled on that
  // same edge loses to the mismatch and restarts the count at one.
  assign err_hit = (state_q == ACK) && mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= 1'b0;
      err_count <= '0;
      err_slot  <= '0;
    end else if (err_hit) begin
      err       <= 1'b1;
      err_slot  <= sel;
      if (clear)                    err_count <= 16'd1;
      else if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end else if (clear) begin
      err       <= 1'b0;
      err_count <= '0;
      err_slot  <= '0;
    end
  end

`ifdef CHK_SCHED_ERRMAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_map <= '0;
    else if (err_hit) err_map <= (clear ? '0 : err_map) | grant;
    else if (clear)   err_map <= '0;
  end
`else
  assign err_map = '0;
`endif

endmodule
